// File: rtl/pos_update_ctrl_pkg.sv
// Shared types, screen limits and clamp helpers for the position update path.
// Also reused by the draw modules for their screen limits.
package pos_update_ctrl_pkg;

    localparam logic [9:0]  TANK_X_MAX   = 10'd736;
    localparam logic [9:0]  TANK_Y_MAX   = 10'd536;
    localparam logic [11:0] MOUSE_X_MAX  = 12'd799;
    localparam logic [11:0] MOUSE_Y_MAX  = 12'd599;
    localparam logic [9:0]  TANK_X_INIT  = 10'd368;
    localparam logic [9:0]  TANK_Y_INIT  = 10'd268;
    localparam logic [9:0]  ENEMY_Y_INIT = 10'd32;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;
    typedef enum logic {SRC_LOC = 1'b0, SRC_REM = 1'b1} src_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
    } tank_pos_t;

    typedef struct packed {
        logic [11:0] x;
        logic [11:0] y;
    } mouse_pos_t;

    function automatic logic [9:0] clamp10(input logic [9:0] v,
                                           input logic [9:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [11:0] clamp12(input logic [11:0] v,
                                            input logic [11:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/pos_update_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the source that wins
// a tie and moves past whichever source was just granted.
module rr_arb2
    import pos_update_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    src_t ptr;

    always_comb begin
        gnt = req;
        if (&req)
            gnt = (ptr == SRC_REM) ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= SRC_LOC;
        else if (advance && |gnt)
            ptr <= gnt[0] ? SRC_REM : SRC_LOC;
    end

endmodule

// File: rtl/pos_update_ctrl.sv
// Arbitrates local/remote position writers into clamped shadow banks and
// commits them to the render side once per frame at vblank start.
module pos_update_ctrl
    import pos_update_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblank,
    input  logic        req_loc,
    input  logic [9:0]  xpos_tank_loc,
    input  logic [9:0]  ypos_tank_loc,
    input  logic [11:0] xpos_mouse_loc,
    input  logic [11:0] ypos_mouse_loc,
    output logic        ack_loc,
    input  logic        req_rem,
    input  logic [9:0]  xpos_enemy_rem,
    input  logic [9:0]  ypos_enemy_rem,
    output logic        ack_rem,
    output logic [9:0]  xpos_tank_out,
    output logic [9:0]  ypos_tank_out,
    output logic [11:0] xpos_mouse_out,
    output logic [11:0] ypos_mouse_out,
    output logic [9:0]  xpos_enemy_out,
    output logic [9:0]  ypos_enemy_out,
    output logic        frame_tick,
    output logic [7:0]  drop_cnt
);

    state_t     state;
    src_t       src;
    logic [1:0] gnt;
    logic       vblank_q, rise;
    logic       wr_loc, wr_rem, dirty_loc, dirty_rem, drop_inc;
    tank_pos_t  sh_tank, sh_enemy, out_tank, out_enemy;
    mouse_pos_t sh_mouse, out_mouse;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     ({req_rem, req_loc}),
        .advance (state == IDLE),
        .gnt     (gnt)
    );

    assign rise   = vblank & ~vblank_q;
    assign wr_loc = (state == IDLE) & gnt[0];
    assign wr_rem = (state == IDLE) & gnt[1];
    // A write on a commit edge does not lose data: the old shadow is committed.
    assign drop_inc = ((wr_loc & dirty_loc) | (wr_rem & dirty_rem)) & ~rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            src     <= SRC_LOC;
            ack_loc <= 1'b0;
            ack_rem <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wr_loc) begin
                        ack_loc <= 1'b1;
                        src     <= SRC_LOC;
                        state   <= HOLD;
                    end else if (wr_rem) begin
                        ack_rem <= 1'b1;
                        src     <= SRC_REM;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if ((src == SRC_LOC) ? !req_loc : !req_rem) begin
                        ack_loc <= 1'b0;
                        ack_rem <= 1'b0;
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_tank   <= '{x: TANK_X_INIT, y: TANK_Y_INIT};
            sh_enemy  <= '{x: TANK_X_INIT, y: ENEMY_Y_INIT};
            sh_mouse  <= '0;
            dirty_loc <= 1'b0;
            dirty_rem <= 1'b0;
            drop_cnt  <= 8'd0;
        end else begin
            if (wr_loc) begin
                sh_tank.x  <= clamp10(xpos_tank_loc, TANK_X_MAX);
                sh_tank.y  <= clamp10(ypos_tank_loc, TANK_Y_MAX);
                sh_mouse.x <= clamp12(xpos_mouse_loc, MOUSE_X_MAX);
                sh_mouse.y <= clamp12(ypos_mouse_loc, MOUSE_Y_MAX);
            end
            if (wr_rem) begin
                sh_enemy.x <= clamp10(xpos_enemy_rem, TANK_X_MAX);
                sh_enemy.y <= clamp10(ypos_enemy_rem, TANK_Y_MAX);
            end
            dirty_loc <= wr_loc | (dirty_loc & ~rise);
            dirty_rem <= wr_rem | (dirty_rem & ~rise);
            if (drop_inc && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblank_q   <= 1'b0;
            frame_tick <= 1'b0;
            out_tank   <= '{x: TANK_X_INIT, y: TANK_Y_INIT};
            out_enemy  <= '{x: TANK_X_INIT, y: ENEMY_Y_INIT};
            out_mouse  <= '0;
        end else begin
            vblank_q   <= vblank;
            frame_tick <= rise;
            if (rise) begin
                out_tank  <= sh_tank;
                out_enemy <= sh_enemy;
                out_mouse <= sh_mouse;
            end
        end
    end

    assign xpos_tank_out  = out_tank.x;
    assign ypos_tank_out  = out_tank.y;
    assign xpos_mouse_out = out_mouse.x;
    assign ypos_mouse_out = out_mouse.y;
    assign xpos_enemy_out = out_enemy.x;
    assign ypos_enemy_out = out_enemy.y;

endmodule

// File: tb/tb_pos_update_ctrl.sv
// Directed bench for pos_update_ctrl: handshake, arbitration, clamping,
// frame commit, drop counting and async reset.
module tb_pos_update_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, vblank, req_loc, req_rem;
    logic [9:0]  xpos_tank_loc, ypos_tank_loc, xpos_enemy_rem, ypos_enemy_rem;
    logic [11:0] xpos_mouse_loc, ypos_mouse_loc;
    logic        ack_loc, ack_rem, frame_tick;
    logic [9:0]  xpos_tank_out, ypos_tank_out, xpos_enemy_out, ypos_enemy_out;
    logic [11:0] xpos_mouse_out, ypos_mouse_out;
    logic [7:0]  drop_cnt;

    int vec = 0;
    int errs = 0;
    int nticks;

    always #5 clk = ~clk;

    pos_update_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vblank         (vblank),
        .req_loc        (req_loc),
        .xpos_tank_loc  (xpos_tank_loc),
        .ypos_tank_loc  (ypos_tank_loc),
        .xpos_mouse_loc (xpos_mouse_loc),
        .ypos_mouse_loc (ypos_mouse_loc),
        .ack_loc        (ack_loc),
        .req_rem        (req_rem),
        .xpos_enemy_rem (xpos_enemy_rem),
        .ypos_enemy_rem (ypos_enemy_rem),
        .ack_rem        (ack_rem),
        .xpos_tank_out  (xpos_tank_out),
        .ypos_tank_out  (ypos_tank_out),
        .xpos_mouse_out (xpos_mouse_out),
        .ypos_mouse_out (ypos_mouse_out),
        .xpos_enemy_out (xpos_enemy_out),
        .ypos_enemy_out (ypos_enemy_out),
        .frame_tick     (frame_tick),
        .drop_cnt       (drop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int tx, input int ty,
                           input int mx, input int my, input int ex,
                           input int ey);
        chk({tag, ".tank_x"}, 32'(xpos_tank_out), tx);
        chk({tag, ".tank_y"}, 32'(ypos_tank_out), ty);
        chk({tag, ".mouse_x"}, 32'(xpos_mouse_out), mx);
        chk({tag, ".mouse_y"}, 32'(ypos_mouse_out), my);
        chk({tag, ".enemy_x"}, 32'(xpos_enemy_out), ex);
        chk({tag, ".enemy_y"}, 32'(ypos_enemy_out), ey);
    endtask

    task automatic loc_xfer(input int tx, input int ty, input int mx,
                            input int my);
        xpos_tank_loc  = 10'(tx);
        ypos_tank_loc  = 10'(ty);
        xpos_mouse_loc = 12'(mx);
        ypos_mouse_loc = 12'(my);
        req_loc = 1'b1;
        tick();
        chk("loc_ack_rise", 32'(ack_loc), 1);
        req_loc = 1'b0;
        tick();
        chk("loc_ack_fall", 32'(ack_loc), 0);
    endtask

    task automatic rem_xfer(input int ex, input int ey);
        xpos_enemy_rem = 10'(ex);
        ypos_enemy_rem = 10'(ey);
        req_rem = 1'b1;
        tick();
        chk("rem_ack_rise", 32'(ack_rem), 1);
        req_rem = 1'b0;
        tick();
        chk("rem_ack_fall", 32'(ack_rem), 0);
    endtask

    task automatic commit();
        vblank = 1'b1;
        tick();
        chk("commit_tick", 32'(frame_tick), 1);
        vblank = 1'b0;
        tick();
        chk("commit_tick_end", 32'(frame_tick), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        vblank = 1'b0;
        req_loc = 1'b0;
        req_rem = 1'b0;
        xpos_tank_loc = '0;
        ypos_tank_loc = '0;
        xpos_mouse_loc = '0;
        ypos_mouse_loc = '0;
        xpos_enemy_rem = '0;
        ypos_enemy_rem = '0;
        #23 rst_n = 1'b1;
        tick();
        tick();

        // 1: reset values
        chk_out("reset", 368, 268, 0, 0, 368, 32);
        chk("reset.ack_loc", 32'(ack_loc), 0);
        chk("reset.ack_rem", 32'(ack_rem), 0);
        chk("reset.frame_tick", 32'(frame_tick), 0);
        chk("reset.drop", 32'(drop_cnt), 0);

        // 2: local update with mouse clamp, visible only after commit
        loc_xfer(100, 200, 900, 700);
        chk_out("precommit", 368, 268, 0, 0, 368, 32);
        commit();
        chk_out("commit1", 100, 200, 799, 599, 368, 32);
        rem_xfer(1000, 600);
        commit();
        chk_out("enemy_clamp", 100, 200, 799, 599, 736, 536);
        chk("drop_after2", 32'(drop_cnt), 0);

        // 3: contention, local wins first then pointer favours remote
        xpos_tank_loc = 10'd50;
        ypos_tank_loc = 10'd60;
        xpos_mouse_loc = 12'd5;
        ypos_mouse_loc = 12'd6;
        xpos_enemy_rem = 10'd70;
        ypos_enemy_rem = 10'd80;
        req_loc = 1'b1;
        req_rem = 1'b1;
        tick();
        chk("arb1.ack_loc", 32'(ack_loc), 1);
        chk("arb1.ack_rem", 32'(ack_rem), 0);
        req_loc = 1'b0;
        tick();
        chk("arb1.loc_rel", 32'(ack_loc), 0);
        chk("arb1.rem_wait", 32'(ack_rem), 0);
        xpos_tank_loc = 10'd51;
        ypos_tank_loc = 10'd61;
        xpos_mouse_loc = 12'd7;
        ypos_mouse_loc = 12'd8;
        req_loc = 1'b1;
        tick();
        chk("arb2.ack_rem", 32'(ack_rem), 1);
        chk("arb2.ack_loc", 32'(ack_loc), 0);
        req_rem = 1'b0;
        tick();
        chk("arb2.rem_rel", 32'(ack_rem), 0);
        tick();
        chk("arb3.ack_loc", 32'(ack_loc), 1);
        req_loc = 1'b0;
        tick();
        chk("arb3.loc_rel", 32'(ack_loc), 0);
        chk("drop_arb", 32'(drop_cnt), 1);
        commit();
        chk_out("commit_arb", 51, 61, 7, 8, 70, 80);

        // 4: overwrite within a frame, then saturation
        loc_xfer(10, 10, 1, 1);
        loc_xfer(20, 20, 2, 2);
        chk("drop_twice", 32'(drop_cnt), 2);
        commit();
        chk_out("commit_last", 20, 20, 2, 2, 70, 80);
        for (int i = 0; i < 300; i++)
            loc_xfer(5, 5, 3, 3);
        chk("drop_sat", 32'(drop_cnt), 255);
        commit();
        chk_out("commit_sat", 5, 5, 3, 3, 70, 80);

        // 5: grant on the commit edge, then long vblank
        xpos_tank_loc = 10'd400;
        ypos_tank_loc = 10'd300;
        xpos_mouse_loc = 12'd9;
        ypos_mouse_loc = 12'd9;
        req_loc = 1'b1;
        vblank = 1'b1;
        tick();
        chk("same_edge.ack", 32'(ack_loc), 1);
        chk("same_edge.tick", 32'(frame_tick), 1);
        chk_out("same_edge", 5, 5, 3, 3, 70, 80);
        req_loc = 1'b0;
        nticks = int'(frame_tick);
        for (int i = 0; i < 49; i++) begin
            tick();
            nticks += int'(frame_tick);
        end
        chk("hold_ticks", 32'(nticks), 1);
        chk("hold_ack", 32'(ack_loc), 0);
        vblank = 1'b0;
        tick();
        commit();
        chk_out("next_commit", 400, 300, 9, 9, 70, 80);
        chk("drop_still_sat", 32'(drop_cnt), 255);

        // 6: async reset during HOLD
        xpos_enemy_rem = 10'd11;
        ypos_enemy_rem = 10'd12;
        req_rem = 1'b1;
        tick();
        chk("hold_rem.ack", 32'(ack_rem), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.ack_rem", 32'(ack_rem), 0);
        chk("async_rst.drop", 32'(drop_cnt), 0);
        chk_out("async_rst", 368, 268, 0, 0, 368, 32);
        #3 rst_n = 1'b1;
        tick();
        chk("regrant.ack_rem", 32'(ack_rem), 1);
        req_rem = 1'b0;
        tick();
        chk("regrant.rel", 32'(ack_rem), 0);
        commit();
        chk_out("regrant_commit", 368, 268, 0, 0, 11, 12);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
